// File: rtl/hazard_fwd_ctrl_if.sv
// ============================================================================
// Module      : hazard_fwd_ctrl_if
// Description : ID-stage hazard/forwarding control bundle between pipeline and controller.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface hazard_fwd_ctrl_if #(
  parameter int AW = 5,
  parameter int IW = 20
);
  logic [IW-1:0] ins;
  logic          id_valid;
  logic          id_wr;
  logic          id_load;
  logic          id_imm;
  logic          flush;
  logic [1:0]    mux_sel_A;
  logic [1:0]    mux_sel_B;
  logic          imm_sel;
  logic [AW-1:0] RW_dm;
  logic          wr_en_dm;
  logic          stall;

  // Pipeline side drives the ID instruction and consumes the controls.
  modport master (
    output ins, id_valid, id_wr, id_load, id_imm, flush,
    input  mux_sel_A, mux_sel_B, imm_sel, RW_dm, wr_en_dm, stall
  );

  modport slave (
    input  ins, id_valid, id_wr, id_load, id_imm, flush,
    output mux_sel_A, mux_sel_B, imm_sel, RW_dm, wr_en_dm, stall
  );
endinterface

`default_nettype wire

// File: rtl/hazard_fwd_ctrl.sv
// ============================================================================
// Module      : hazard_fwd_ctrl
// Description : Load-use stall and operand-forwarding control for a 4-stage pipeline.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module hazard_fwd_ctrl #(
  parameter int AW = 5,
  parameter int IW = 20
) (
  input  wire logic          clk,
  input  wire logic          reset,
  hazard_fwd_ctrl_if.slave   bus
);

  localparam logic [1:0] c_SEL_BANK = 2'b00;
  localparam logic [1:0] c_SEL_EX   = 2'b01;
  localparam logic [1:0] c_SEL_DM   = 2'b10;
  localparam logic [1:0] c_SEL_WB   = 2'b11;

  typedef struct packed {
    logic          valid;
    logic          wr;
    logic          load;
    logic [AW-1:0] rd;
  } stage_t;

  stage_t        ex_q, ex_d;
  stage_t        dm_q, dm_d;
  stage_t        wb_q, wb_d;
  stage_t        id_rec;
  logic [1:0]    mux_sel_a_q, mux_sel_a_d;
  logic [1:0]    mux_sel_b_q, mux_sel_b_d;
  logic          imm_sel_q, imm_sel_d;
  logic [AW-1:0] rw_dm_q, rw_dm_d;
  logic          wr_en_dm_q, wr_en_dm_d;
  logic [AW-1:0] ra, rb;
  logic          load_use;
  logic          accept;
  logic          unused_ok;

  assign ra = bus.ins[9:5];
  assign rb = bus.ins[4:0];

  // Youngest in-flight producer of src wins.
  function automatic logic [1:0] fwd_sel(
    input logic [AW-1:0] src,
    input stage_t        ex,
    input stage_t        dm,
    input stage_t        wb
  );
    if (ex.valid && ex.wr && (ex.rd == src)) return c_SEL_EX;
    if (dm.valid && dm.wr && (dm.rd == src)) return c_SEL_DM;
    if (wb.valid && wb.wr && (wb.rd == src)) return c_SEL_WB;
    return c_SEL_BANK;
  endfunction

  always_comb begin
    id_rec       = '0;
    id_rec.valid = bus.id_valid;
    id_rec.wr    = bus.id_wr;
    id_rec.load  = bus.id_load;
    id_rec.rd    = bus.ins[14:10];

    // A load in EX only has its data at the DM mux next cycle.
    load_use = 1'b0;
    if (bus.id_valid && !bus.flush && ex_q.valid && ex_q.load && ex_q.wr) begin
      load_use = (ex_q.rd == ra) || (!bus.id_imm && (ex_q.rd == rb));
    end
    accept = bus.id_valid && !bus.flush && !load_use;

    ex_d = accept ? id_rec : '0;
    dm_d = ex_q;
    wb_d = dm_q;

    mux_sel_a_d = c_SEL_BANK;
    mux_sel_b_d = c_SEL_BANK;
    imm_sel_d   = 1'b0;
    if (accept) begin
      mux_sel_a_d = fwd_sel(ra, ex_q, dm_q, wb_q);
      imm_sel_d   = bus.id_imm;
      if (!bus.id_imm) begin
        mux_sel_b_d = fwd_sel(rb, ex_q, dm_q, wb_q);
      end
    end

    wr_en_dm_d = dm_q.valid && dm_q.wr;
    rw_dm_d    = dm_q.valid ? dm_q.rd : rw_dm_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ex_q        <= '0;
      dm_q        <= '0;
      wb_q        <= '0;
      mux_sel_a_q <= c_SEL_BANK;
      mux_sel_b_q <= c_SEL_BANK;
      imm_sel_q   <= 1'b0;
      rw_dm_q     <= '0;
      wr_en_dm_q  <= 1'b0;
    end else begin
      ex_q        <= ex_d;
      dm_q        <= dm_d;
      wb_q        <= wb_d;
      mux_sel_a_q <= mux_sel_a_d;
      mux_sel_b_q <= mux_sel_b_d;
      imm_sel_q   <= imm_sel_d;
      rw_dm_q     <= rw_dm_d;
      wr_en_dm_q  <= wr_en_dm_d;
    end
  end

  assign bus.mux_sel_A = mux_sel_a_q;
  assign bus.mux_sel_B = mux_sel_b_q;
  assign bus.imm_sel   = imm_sel_q;
  assign bus.RW_dm     = rw_dm_q;
  assign bus.wr_en_dm  = wr_en_dm_q;
  assign bus.stall     = load_use;

  // Opcode bits and late-stage load flags carry no hazard information.
  assign unused_ok = ^{bus.ins[IW-1:15], dm_q.load, wb_q.load};

endmodule

`default_nettype wire

// File: tb/tb_hazard_fwd_ctrl.sv
// ============================================================================
// Module      : tb_hazard_fwd_ctrl
// Description : Directed self-checking bench for hazard_fwd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_hazard_fwd_ctrl;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fail;

  hazard_fwd_ctrl_if #(.AW(5), .IW(20)) bus ();

  hazard_fwd_ctrl #(.AW(5), .IW(20)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Drive one ID slot on the falling edge.
  task automatic drive(input logic v, input logic wr, input logic ld, input logic imm,
                       input logic fl, input logic [4:0] rw, input logic [4:0] ra,
                       input logic [4:0] rb);
    @(negedge clk);
    bus.id_valid = v;
    bus.id_wr    = wr;
    bus.id_load  = ld;
    bus.id_imm   = imm;
    bus.flush    = fl;
    bus.ins      = {5'd0, rw, ra, rb};
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 5'd0);
  endtask

  task automatic alu(input logic [4:0] rw, input logic [4:0] ra, input logic [4:0] rb);
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, rw, ra, rb);
  endtask

  task automatic load(input logic [4:0] rw);
    drive(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, rw, 5'd1, 5'd2);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_sels(input string tag, input logic [1:0] a, input logic [1:0] b,
                          input logic imm);
    chk({tag, "_selA"}, {6'd0, bus.mux_sel_A}, {6'd0, a});
    chk({tag, "_selB"}, {6'd0, bus.mux_sel_B}, {6'd0, b});
    chk({tag, "_imm"},  {7'd0, bus.imm_sel},   {7'd0, imm});
  endtask

  task automatic chk_all_zero(input string tag);
    chk_sels(tag, 2'b00, 2'b00, 1'b0);
    chk({tag, "_rw"},    {3'd0, bus.RW_dm},   8'd0);
    chk({tag, "_wren"},  {7'd0, bus.wr_en_dm}, 8'd0);
    chk({tag, "_stall"}, {7'd0, bus.stall},   8'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b0;
    bus.id_valid = 1'b0; bus.id_wr = 1'b0; bus.id_load = 1'b0;
    bus.id_imm   = 1'b0; bus.flush = 1'b0; bus.ins = '0;
    repeat (3) @(posedge clk);
    #1;
    chk_all_zero("por");
    @(negedge clk);
    reset = 1'b1;

    // RAW on the immediately preceding writer forwards from EX.
    alu(5'd3, 5'd1, 5'd2);
    tick(); chk_sels("add1", 2'b00, 2'b00, 1'b0);
    alu(5'd4, 5'd3, 5'd3);
    #1 chk("add2_stall", {7'd0, bus.stall}, 8'd0);
    tick(); chk_sels("add2", 2'b01, 2'b01, 1'b0);
    idle();
    tick();
    chk("wb_r3_en", {7'd0, bus.wr_en_dm}, 8'd1);
    chk("wb_r3_rw", {3'd0, bus.RW_dm}, 8'd3);
    chk_sels("idle_sel", 2'b00, 2'b00, 1'b0);
    idle();
    tick();
    chk("wb_r4_en", {7'd0, bus.wr_en_dm}, 8'd1);
    chk("wb_r4_rw", {3'd0, bus.RW_dm}, 8'd4);
    idle();
    tick();
    chk("bub_en", {7'd0, bus.wr_en_dm}, 8'd0);
    chk("bub_rw_hold", {3'd0, bus.RW_dm}, 8'd4);

    // Distance 2 -> DM, distance 3 -> WB.
    alu(5'd5, 5'd0, 5'd0);  tick();
    alu(5'd6, 5'd1, 5'd2);  tick();
    alu(5'd8, 5'd5, 5'd9);  tick(); chk_sels("dist2", 2'b10, 2'b00, 1'b0);
    alu(5'd10, 5'd1, 5'd2); tick();
    alu(5'd11, 5'd1, 5'd2); tick();
    alu(5'd12, 5'd1, 5'd2); tick();
    alu(5'd14, 5'd10, 5'd1); tick(); chk_sels("dist3", 2'b11, 2'b00, 1'b0);

    // Two writers of R13: only the younger one is selected.
    alu(5'd13, 5'd1, 5'd2);  tick();
    alu(5'd13, 5'd1, 5'd2);  tick();
    alu(5'd15, 5'd13, 5'd13); tick(); chk_sels("youngest", 2'b01, 2'b01, 1'b0);

    // R0 forwards like any other register.
    alu(5'd0, 5'd1, 5'd2); tick();
    alu(5'd1, 5'd0, 5'd0); tick(); chk_sels("r0", 2'b01, 2'b01, 1'b0);
    repeat (3) begin idle(); tick(); end

    // Load-use on RA: one stall, bubble, then DM forward.
    load(5'd7); tick();
    alu(5'd8, 5'd7, 5'd1);
    #1 chk("lu_stall1", {7'd0, bus.stall}, 8'd1);
    tick(); chk_sels("lu_bubble", 2'b00, 2'b00, 1'b0);
    #1 chk("lu_stall2", {7'd0, bus.stall}, 8'd0);
    tick(); chk_sels("lu_fwd", 2'b10, 2'b00, 1'b0);
    repeat (3) begin idle(); tick(); end

    // Immediate operand hides RB from the load.
    load(5'd7); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 5'd8, 5'd2, 5'd7);
    #1 chk("imm_stall", {7'd0, bus.stall}, 8'd0);
    tick(); chk_sels("imm", 2'b00, 2'b00, 1'b1);
    repeat (3) begin idle(); tick(); end

    // Load-use on RB without immediate.
    load(5'd9); tick();
    alu(5'd8, 5'd1, 5'd9);
    #1 chk("lub_stall", {7'd0, bus.stall}, 8'd1);
    tick(); chk_sels("lub_bubble", 2'b00, 2'b00, 1'b0);
    tick(); chk_sels("lub_fwd", 2'b00, 2'b10, 1'b0);
    repeat (3) begin idle(); tick(); end

    // Flush wins over stall and leaves a dead DM slot.
    load(5'd7); tick();
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd8, 5'd7, 5'd1);
    #1 chk("fl_stall", {7'd0, bus.stall}, 8'd0);
    tick(); chk_sels("fl_sel", 2'b00, 2'b00, 1'b0);
    idle(); tick();
    chk("fl_ld_en", {7'd0, bus.wr_en_dm}, 8'd1);
    chk("fl_ld_rw", {3'd0, bus.RW_dm}, 8'd7);
    idle(); tick();
    chk("fl_slot_en", {7'd0, bus.wr_en_dm}, 8'd0);
    chk("fl_slot_rw", {3'd0, bus.RW_dm}, 8'd7);

    // Asynchronous reset in the middle of traffic.
    alu(5'd20, 5'd1, 5'd2);  tick();
    alu(5'd21, 5'd20, 5'd1); tick(); chk_sels("pre_rst", 2'b01, 2'b00, 1'b0);
    load(5'd22); tick();
    chk("pre_rst_en", {7'd0, bus.wr_en_dm}, 8'd1);
    alu(5'd23, 5'd22, 5'd1);
    #1 chk("pre_rst_stall", {7'd0, bus.stall}, 8'd1);
    #1 reset = 1'b0;
    #1 chk_all_zero("mid_rst");
    bus.id_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    bus.id_valid = 1'b1; bus.id_wr = 1'b1; bus.id_load = 1'b0;
    bus.id_imm = 1'b0; bus.flush = 1'b0; bus.ins = {5'd0, 5'd23, 5'd1, 5'd2};
    tick();
    chk("rel1_en", {7'd0, bus.wr_en_dm}, 8'd0);
    idle(); tick();
    chk("rel2_en", {7'd0, bus.wr_en_dm}, 8'd0);
    chk("rel2_rw", {3'd0, bus.RW_dm}, 8'd0);
    idle(); tick();
    chk("rel3_en", {7'd0, bus.wr_en_dm}, 8'd1);
    chk("rel3_rw", {3'd0, bus.RW_dm}, 8'd23);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
